// File: rtl/mux_salida.sv
// Output-stage 2:1 bus selector: forwards first_bus or second_bus, chosen by sel,
// to a registered result bus with a synchronous active-high reset.
module mux_salida #(
   parameter int unsigned           WIDTH       = 8,
   parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] first_bus,
   input  logic [WIDTH-1:0] second_bus,
   input  logic             sel,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH-1:0] result_d;
   logic [WIDTH-1:0] result_q;

   // Next-state selection; bits pass through unmodified.
   always_comb begin
      result_d = first_bus;
      if (sel == 1'b1) begin
         result_d = second_bus;
      end else begin
         result_d = first_bus;
      end
   end

   // Output register; rst wins over every other input on the same edge.
   always_ff @(posedge clk) begin
      if (rst == 1'b1) begin
         result_q <= RESET_VALUE;
      end else begin
         result_q <= result_d;
      end
   end

   assign result = result_q;

endmodule

// File: tb/tb_mux_salida.sv
// Directed bench for mux_salida: expected values are queued when stimulus is driven
// and compared one edge later when the registered output settles.
module tb_mux_salida;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] first_bus;
   logic [WIDTH-1:0] second_bus;
   logic             sel;
   logic [WIDTH-1:0] result;

   logic [WIDTH-1:0] exp_q[$];
   logic [WIDTH-1:0] last_exp;
   int               checks;
   int               failures;

   mux_salida #(.WIDTH(WIDTH), .RESET_VALUE(8'd0)) dut (
      .clk        (clk),
      .rst        (rst),
      .first_bus  (first_bus),
      .second_bus (second_bus),
      .sel        (sel),
      .result     (result)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply inputs and queue what result must hold after the next rising edge.
   task automatic drive(input logic r, input logic [WIDTH-1:0] fb,
                        input logic [WIDTH-1:0] sb, input logic s);
      logic [WIDTH-1:0] e;
      rst        = r;
      first_bus  = fb;
      second_bus = sb;
      sel        = s;
      if (r) e = 8'd0;
      else if (s) e = sb;
      else e = fb;
      exp_q.push_back(e);
   endtask

   task automatic tick_check(input string tag);
      logic [WIDTH-1:0] e;
      @(posedge clk);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $error("FAIL %s scoreboard empty observed=%0d", tag, result);
      end else begin
         e = exp_q.pop_front();
         last_exp = e;
         assert (result === e) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, result, e);
         end
      end
   endtask

   task automatic hold_check(input string tag);
      checks++;
      assert (result === last_exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, result, last_exp);
      end
   endtask

   initial begin
      logic [WIDTH-1:0] rf, rs;
      logic             rsel;
      checks = 0; failures = 0; last_exp = 8'd0;
      rst = 1'b1; first_bus = 8'd0; second_bus = 8'd0; sel = 1'b0;

      drive(1'b1, 8'd10, 8'd50, 1'b0); tick_check("reset_cyc0");
      drive(1'b1, 8'd10, 8'd50, 1'b0); tick_check("reset_cyc1");
      drive(1'b0, 8'd10, 8'd50, 1'b0); tick_check("reset_release");

      drive(1'b0, 8'd10, 8'd50, 1'b1); tick_check("sel_to_second");
      drive(1'b0, 8'd10, 8'd50, 1'b0); tick_check("sel_to_first");

      drive(1'b0, 8'd30, 8'd50, 1'b0); tick_check("first_upd_30");
      drive(1'b0, 8'd80, 8'd50, 1'b0); tick_check("first_upd_80");

      drive(1'b0, 8'd80, 8'd50, 1'b1); tick_check("sel1_second50");
      drive(1'b0, 8'd30, 8'd50, 1'b1); tick_check("iso_first_change");
      drive(1'b0, 8'd30, 8'd50, 1'b0); tick_check("sel0_first30");
      drive(1'b0, 8'd30, 8'd200, 1'b0); tick_check("iso_second_change");

      drive(1'b0, 8'd30, 8'd255, 1'b1); tick_check("second_255");
      drive(1'b1, 8'd30, 8'd255, 1'b1); tick_check("midstream_reset");
      drive(1'b0, 8'd30, 8'd255, 1'b1); tick_check("after_reset_255");

      drive(1'b0, 8'd0,   8'd255, 1'b0); tick_check("first_0");
      drive(1'b0, 8'd0,   8'd255, 1'b1); tick_check("second_255_b");
      drive(1'b0, 8'd255, 8'd0,   1'b0); tick_check("first_255");
      drive(1'b0, 8'd255, 8'd0,   1'b1); tick_check("second_0");

      // Mid-cycle changes must not reach result before the next edge.
      #2;
      sel = 1'b0; first_bus = 8'd77;
      #1; hold_check("latency_hold_a");
      first_bus = 8'd99; second_bus = 8'd11;
      #2; hold_check("latency_hold_b");
      drive(1'b0, 8'd99, 8'd11, 1'b0);
      tick_check("latency_update");

      // Per-cycle sel toggling with random data: no skipped or repeated samples.
      for (int i = 0; i < 16; i++) begin
         rf   = WIDTH'($urandom_range(0, 255));
         rs   = WIDTH'($urandom_range(0, 255));
         rsel = i[0];
         drive(1'b0, rf, rs, rsel);
         tick_check("toggle_random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
